// File: rtl/rx_libnet_pkg.sv
// Shared types and default header field offsets for the multi-channel receive libnet.
package rx_libnet_pkg;

   typedef enum logic [1:0] {
      PARSE  = 2'd0,
      STREAM = 2'd1,
      DROP   = 2'd2
   } state_e;

   localparam int SEQ_LSB_DEF = 344;
   localparam int SYN_BIT_DEF = 377;
   localparam int CH_LSB_DEF  = 384;

endpackage

// File: rtl/rx_libnet_mc_if.sv
// AXI-Stream bundle used on both the sysnet (slave) and application (master) sides.
interface rx_libnet_mc_if #(
   parameter int DATA_W = 512,
   parameter int USER_W = 64,
   parameter int CH_W   = 2
);
   logic [DATA_W-1:0]   tdata;
   logic [DATA_W/8-1:0] tkeep;
   logic [USER_W-1:0]   tuser;
   logic [CH_W-1:0]     tdest;
   logic                tlast;
   logic                tvalid;
   logic                tready;

   modport master (output tdata, tkeep, tuser, tdest, tlast, tvalid, input tready);
   modport slave  (input tdata, tkeep, tuser, tdest, tlast, tvalid, output tready);
endinterface

// File: rtl/rx_libnet_mc_axis_reg_slice.sv
// One-deep registered AXI-Stream output stage; can_load says a new beat may be written this cycle.
module axis_reg_slice
   import rx_libnet_pkg::*;
#(
   parameter int DATA_W = 512,
   parameter int USER_W = 64,
   parameter int CH_W   = 2
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                load,
   input  logic [DATA_W-1:0]   d_data,
   input  logic [DATA_W/8-1:0] d_keep,
   input  logic [USER_W-1:0]   d_user,
   input  logic [CH_W-1:0]     d_dest,
   input  logic                d_last,
   output logic                can_load,
   rx_libnet_mc_if.master      m
);

   assign can_load = !m.tvalid || m.tready;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         m.tvalid <= 1'b0;
         m.tdata  <= '0;
         m.tkeep  <= '0;
         m.tuser  <= '0;
         m.tdest  <= '0;
         m.tlast  <= 1'b0;
      end else if (load) begin
         m.tvalid <= 1'b1;
         m.tdata  <= d_data;
         m.tkeep  <= d_keep;
         m.tuser  <= d_user;
         m.tdest  <= d_dest;
         m.tlast  <= d_last;
      end else if (m.tvalid && m.tready) begin
         m.tvalid <= 1'b0;
      end
   end

endmodule

// File: rtl/rx_libnet_mc.sv
// Multi-channel receive libnet: per-channel sequence tracking, header strip, in-order forward, acks.
// Optional statistics counters are enabled with RX_LIBNET_MC_STATS_EN.
module rx_libnet_mc
   import rx_libnet_pkg::*;
#(
   parameter int DATA_W  = 512,
   parameter int USER_W  = 64,
   parameter int NUM_CH  = 4,
   parameter int CH_W    = 2,
   parameter int SEQ_W   = 32,
   parameter int SEQ_LSB = SEQ_LSB_DEF,
   parameter int SYN_BIT = SYN_BIT_DEF,
   parameter int CH_LSB  = CH_LSB_DEF
) (
   input  logic             clk,
   input  logic             resetn,
   rx_libnet_mc_if.slave    rx,
   rx_libnet_mc_if.master   tx,
   output logic             ack_valid,
   input  logic             ack_ready,
   output logic [CH_W-1:0]  ack_ch,
   output logic [SEQ_W-1:0] ack_seq,
   output logic [1:0]       dbg_state
`ifdef RX_LIBNET_MC_STATS_EN
   ,
   output logic [31:0]      drop_cnt,
   output logic [31:0]      syn_cnt
`endif
);

   // Handshakes: a transfer happens on a rising clk edge where valid && ready; the sender
   // holds payload stable while valid && !ready and never drops valid until the transfer.

   localparam logic [1:0] ST_PARSE  = PARSE;
   localparam logic [1:0] ST_STREAM = STREAM;
   localparam logic [1:0] ST_DROP   = DROP;
   localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [1:0]       state;
   logic [SEQ_W-1:0] seq_tbl [NUM_CH];
   logic [CH_W-1:0]  cur_ch;

   logic [CH_W-1:0]  h_ch;
   logic [IDX_W-1:0] h_idx;
   logic [SEQ_W-1:0] h_seq;
   logic [SEQ_W-1:0] tbl_seq;
   logic             h_syn;
   logic             ch_ok;
   logic             rx_rdy;
   logic             acc;
   logic             hdr_acc;
   logic             can_load;

   assign h_ch    = rx.tdata[CH_LSB +: CH_W];
   assign h_idx   = h_ch[IDX_W-1:0];
   assign h_seq   = rx.tdata[SEQ_LSB +: SEQ_W];
   assign h_syn   = rx.tdata[SYN_BIT];
   assign ch_ok   = 32'(h_ch) < NUM_CH;
   assign tbl_seq = ch_ok ? seq_tbl[h_idx] : '0;

   // A pending ack only holds back headers; payload and drop beats keep flowing.
   always_comb begin
      rx_rdy = 1'b1;
      case (state)
         ST_PARSE:  rx_rdy = !ack_valid;
         ST_STREAM: rx_rdy = can_load;
         default:   rx_rdy = 1'b1;
      endcase
   end

   assign rx.tready = rx_rdy;
   assign acc       = rx.tvalid && rx_rdy;
   assign hdr_acc   = acc && (state == ST_PARSE);
   assign dbg_state = state;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state     <= ST_PARSE;
         cur_ch    <= '0;
         ack_valid <= 1'b0;
         ack_ch    <= '0;
         ack_seq   <= '0;
         for (int i = 0; i < NUM_CH; i++) seq_tbl[i] <= '0;
      end else begin
         if (ack_valid && ack_ready) ack_valid <= 1'b0;
         case (state)
            ST_PARSE: begin
               if (hdr_acc) begin
                  if (!ch_ok) begin
                     state <= rx.tlast ? ST_PARSE : ST_DROP;
                  end else begin
                     ack_valid <= 1'b1;
                     ack_ch    <= h_ch;
                     if (h_syn) begin
                        seq_tbl[h_idx] <= h_seq;
                        ack_seq        <= h_seq;
                        state          <= rx.tlast ? ST_PARSE : ST_DROP;
                     end else if (h_seq == tbl_seq) begin
                        seq_tbl[h_idx] <= h_seq + 1'b1;
                        ack_seq        <= h_seq + 1'b1;
                        cur_ch         <= h_ch;
                        state          <= rx.tlast ? ST_PARSE : ST_STREAM;
                     end else begin
                        ack_seq <= tbl_seq;
                        state   <= rx.tlast ? ST_PARSE : ST_DROP;
                     end
                  end
               end
            end
            default: begin
               if (acc && rx.tlast) state <= ST_PARSE;
            end
         endcase
      end
   end

   axis_reg_slice #(
      .DATA_W (DATA_W),
      .USER_W (USER_W),
      .CH_W   (CH_W)
   ) u_slice (
      .clk      (clk),
      .resetn   (resetn),
      .load     (acc && (state == ST_STREAM)),
      .d_data   (rx.tdata),
      .d_keep   (rx.tkeep),
      .d_user   (rx.tuser),
      .d_dest   (cur_ch),
      .d_last   (rx.tlast),
      .can_load (can_load),
      .m        (tx)
   );

`ifdef RX_LIBNET_MC_STATS_EN
   // Bad-channel headers count as drops even when SYN is set, since they never reach the table.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         drop_cnt <= '0;
         syn_cnt  <= '0;
      end else if (hdr_acc) begin
         if (!ch_ok || (!h_syn && (h_seq != tbl_seq))) begin
            if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
         end else if (h_syn) begin
            if (syn_cnt != '1) syn_cnt <= syn_cnt + 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_rx_libnet_mc.sv
// Scoreboard bench for rx_libnet_mc: directed packets followed by a randomized packet mix.
module tb_rx_libnet_mc;

   localparam int DATA_W  = 512;
   localparam int USER_W  = 64;
   localparam int NUM_CH  = 4;
   localparam int CH_W    = 3;
   localparam int SEQ_W   = 32;
   localparam int KEEP_W  = DATA_W / 8;
   localparam int SEQ_LSB = 344;
   localparam int SYN_BIT = 377;
   localparam int CH_LSB  = 384;
   localparam int PW      = DATA_W + KEEP_W + USER_W + CH_W + 1;
   localparam int AW      = CH_W + SEQ_W;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   rx_libnet_mc_if #(.DATA_W(DATA_W), .USER_W(USER_W), .CH_W(CH_W)) rx_if ();
   rx_libnet_mc_if #(.DATA_W(DATA_W), .USER_W(USER_W), .CH_W(CH_W)) tx_if ();

   logic             ack_valid;
   logic             ack_ready;
   logic [CH_W-1:0]  ack_ch;
   logic [SEQ_W-1:0] ack_seq;
   logic [1:0]       dbg_state;
`ifdef RX_LIBNET_MC_STATS_EN
   logic [31:0]      drop_cnt;
   logic [31:0]      syn_cnt;
`endif

   rx_libnet_mc #(
      .DATA_W (DATA_W), .USER_W (USER_W), .NUM_CH (NUM_CH), .CH_W (CH_W), .SEQ_W (SEQ_W),
      .SEQ_LSB (SEQ_LSB), .SYN_BIT (SYN_BIT), .CH_LSB (CH_LSB)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .rx        (rx_if),
      .tx        (tx_if),
      .ack_valid (ack_valid),
      .ack_ready (ack_ready),
      .ack_ch    (ack_ch),
      .ack_seq   (ack_seq),
      .dbg_state (dbg_state)
`ifdef RX_LIBNET_MC_STATS_EN
      ,
      .drop_cnt  (drop_cnt),
      .syn_cnt   (syn_cnt)
`endif
   );

   int errors = 0;
   int checks = 0;

   function automatic void chk(input bit ok, input string name, input string detail);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: %s", name, detail);
      end
   endfunction

   // ---------------- reference model and scoreboard ----------------
   logic [SEQ_W-1:0] mtbl [NUM_CH];
   logic [PW-1:0]    exp_tx_q[$];
   logic [AW-1:0]    exp_ack_q[$];

   // Returns whether the packet's payload is to be forwarded.
   function automatic bit model_hdr(input logic [CH_W-1:0] ch, input logic [SEQ_W-1:0] seq,
                                    input bit syn);
      if (int'(ch) >= NUM_CH) return 1'b0;
      if (syn) begin
         mtbl[ch] = seq;
         exp_ack_q.push_back({ch, seq});
         return 1'b0;
      end
      if (seq == mtbl[ch]) begin
         mtbl[ch] = seq + 32'd1;
         exp_ack_q.push_back({ch, mtbl[ch]});
         return 1'b1;
      end
      exp_ack_q.push_back({ch, mtbl[ch]});
      return 1'b0;
   endfunction

   // ---------------- sink-side ready drivers ----------------
   int tx_mode  = 0;  // 0: ready high, 1: random, 2: toggle
   int ack_mode = 0;  // 0: ready high, 1: random, 2: held low

   initial begin
      tx_if.tready = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (tx_mode)
            0:       tx_if.tready = 1'b1;
            1:       tx_if.tready = 1'($urandom_range(0, 1));
            default: tx_if.tready = !tx_if.tready;
         endcase
      end
   end

   initial begin
      ack_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (ack_mode)
            0:       ack_ready = 1'b1;
            1:       ack_ready = 1'($urandom_range(0, 1));
            default: ack_ready = 1'b0;
         endcase
      end
   end

   // ---------------- monitors ----------------
   logic [PW-1:0] prev_tx;
   bit            prev_tx_stall = 1'b0;
   logic [AW-1:0] prev_ack;
   bit            prev_ack_stall = 1'b0;

   initial begin
      logic [PW-1:0] cur_tx, e_tx;
      logic [AW-1:0] cur_ack, e_ack;
      forever begin
         @(negedge clk);
         if (resetn) begin
            cur_tx = {tx_if.tdata, tx_if.tkeep, tx_if.tuser, tx_if.tdest, tx_if.tlast};
            if (prev_tx_stall)
               chk(tx_if.tvalid === 1'b1 && cur_tx === prev_tx, "tx_stable",
                   $sformatf("valid=%b dest=%0d last=%b changed while stalled",
                             tx_if.tvalid, tx_if.tdest, tx_if.tlast));
            if (tx_if.tvalid && tx_if.tready) begin
               if (exp_tx_q.size() == 0) begin
                  chk(1'b0, "tx_unexpected", $sformatf("got dest=%0d last=%b, want none",
                                                       tx_if.tdest, tx_if.tlast));
               end else begin
                  e_tx = exp_tx_q.pop_front();
                  chk(cur_tx === e_tx, "tx_beat", $sformatf("got %h want %h", cur_tx, e_tx));
               end
            end
            prev_tx_stall = tx_if.tvalid && !tx_if.tready;
            prev_tx = cur_tx;

            cur_ack = {ack_ch, ack_seq};
            if (prev_ack_stall)
               chk(ack_valid === 1'b1 && cur_ack === prev_ack, "ack_stable",
                   $sformatf("got v=%b ch=%0d seq=%h want v=1 ch=%0d seq=%h", ack_valid,
                             ack_ch, ack_seq, prev_ack[AW-1 -: CH_W], prev_ack[SEQ_W-1:0]));
            if (ack_valid && ack_ready) begin
               if (exp_ack_q.size() == 0) begin
                  chk(1'b0, "ack_unexpected", $sformatf("got ch=%0d seq=%h, want none",
                                                        ack_ch, ack_seq));
               end else begin
                  e_ack = exp_ack_q.pop_front();
                  chk(cur_ack === e_ack, "ack", $sformatf("got ch=%0d seq=%h want ch=%0d seq=%h",
                      ack_ch, ack_seq, e_ack[AW-1 -: CH_W], e_ack[SEQ_W-1:0]));
               end
            end
            prev_ack_stall = ack_valid && !ack_ready;
            prev_ack = cur_ack;
         end
      end
   end

   // ---------------- stimulus drivers ----------------
   function automatic logic [DATA_W-1:0] rand_data();
      logic [DATA_W-1:0] d;
      for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom();
      return d;
   endfunction

   task automatic send_beat(input logic [DATA_W-1:0] d, input logic [KEEP_W-1:0] keep,
                            input logic [USER_W-1:0] user, input bit last, input int gap,
                            output bit ok, output int waits);
      bit go = 1'b0;
      waits = 0;
      repeat (gap) begin @(posedge clk); #1; end
      rx_if.tdata  = d;
      rx_if.tkeep  = keep;
      rx_if.tuser  = user;
      rx_if.tlast  = last;
      rx_if.tvalid = 1'b1;
      while (!go && waits < 2000) begin
         @(negedge clk);
         go = rx_if.tready;
         @(posedge clk); #1;
         waits++;
      end
      rx_if.tvalid = 1'b0;
      ok = go;
      if (!go) chk(1'b0, "rx_timeout", "got rx_tready=0 for 2000 cycles, want acceptance");
   endtask

   // nbeats includes the header; max_gap inserts random idle cycles before each beat.
   task automatic send_pkt(input logic [CH_W-1:0] ch, input logic [SEQ_W-1:0] seq, input bit syn,
                           input int nbeats, input int max_gap, input bit chk_tput);
      logic [DATA_W-1:0] d;
      logic [KEEP_W-1:0] keep;
      logic [USER_W-1:0] user;
      bit fwd, ok, last;
      int waits;
      d = rand_data();
      d[CH_LSB +: CH_W]   = ch;
      d[SEQ_LSB +: SEQ_W] = seq;
      d[SYN_BIT]          = syn;
      fwd = model_hdr(ch, seq, syn);
      send_beat(d, KEEP_W'({$urandom(), $urandom()}), USER_W'({$urandom(), $urandom()}),
                nbeats == 1, $urandom_range(0, max_gap), ok, waits);
      if (!ok) return;
      for (int b = 1; b < nbeats; b++) begin
         d    = rand_data();
         keep = KEEP_W'({$urandom(), $urandom()});
         user = USER_W'({$urandom(), $urandom()});
         last = (b == nbeats - 1);
         if (fwd) exp_tx_q.push_back({d, keep, user, ch, last});
         send_beat(d, keep, user, last, $urandom_range(0, max_gap), ok, waits);
         if (!ok) return;
         if (fwd)
            chk(tx_if.tvalid === 1'b1 && tx_if.tdata === d, "tx_latency",
                $sformatf("got valid=%b one cycle after accept, want 1 with accepted data",
                          tx_if.tvalid));
         if (chk_tput)
            chk(waits == 1, "throughput", $sformatf("got %0d cycles for beat %0d, want 1",
                                                   waits, b));
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      bit ok;
      int waits;
      int ch, sel, nb, budget;
      logic [SEQ_W-1:0] seq;

      for (int i = 0; i < NUM_CH; i++) mtbl[i] = '0;
      rx_if.tdata = '0; rx_if.tkeep = '0; rx_if.tuser = '0; rx_if.tdest = '0;
      rx_if.tlast = 1'b0; rx_if.tvalid = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk(tx_if.tvalid === 1'b0 && ack_valid === 1'b0, "reset_valids",
          $sformatf("got tx_tvalid=%b ack_valid=%b want 0 0", tx_if.tvalid, ack_valid));
      chk(tx_if.tdata === '0 && tx_if.tkeep === '0 && tx_if.tuser === '0 && tx_if.tdest === '0,
          "reset_tx_regs", $sformatf("got tdest=%0d tdata nonzero=%b want all 0",
                                     tx_if.tdest, |tx_if.tdata));
      chk(ack_ch === '0 && ack_seq === '0, "reset_ack_regs",
          $sformatf("got ch=%0d seq=%h want 0 0", ack_ch, ack_seq));
      @(posedge clk); #1;
      resetn = 1'b1;
      @(negedge clk);
      chk(rx_if.tready === 1'b1, "reset_rx_ready", $sformatf("got %b want 1", rx_if.tready));
      @(posedge clk); #1;

      // SYN header-only, then in-order data, then a duplicate
      send_pkt(3'd1, 32'h100, 1'b1, 1, 0, 1'b0);
      send_pkt(3'd1, 32'h100, 1'b0, 3, 0, 1'b1);
      send_pkt(3'd1, 32'h100, 1'b0, 4, 0, 1'b0);

      // sequence wrap on ch0, ch2 still at its reset value
      send_pkt(3'd0, 32'hFFFF_FFFF, 1'b1, 1, 0, 1'b0);
      send_pkt(3'd0, 32'hFFFF_FFFF, 1'b0, 2, 0, 1'b0);
      send_pkt(3'd2, 32'h0, 1'b0, 3, 0, 1'b0);

      // toggling tx_tready over a 6-payload-beat stream
      tx_mode = 2;
      send_pkt(3'd1, 32'h101, 1'b0, 7, 0, 1'b0);
      tx_mode = 0;

      // ack held off: next header must stall
      ack_mode = 2;
      send_pkt(3'd3, 32'h7, 1'b1, 1, 0, 1'b0);
      repeat (10) begin
         @(negedge clk);
         chk(ack_valid === 1'b1 && rx_if.tready === 1'b0, "ack_stall",
             $sformatf("got ack_valid=%b rx_tready=%b want 1 0", ack_valid, rx_if.tready));
      end
      @(posedge clk); #1;
      ack_mode = 0;
      send_pkt(3'd5, 32'h0, 1'b0, 3, 0, 1'b0);
      send_pkt(3'd3, 32'h7, 1'b0, 2, 0, 1'b0);

      // randomized mix
      for (int p = 0; p < 60; p++) begin
         tx_mode  = $urandom_range(0, 2);
         ack_mode = $urandom_range(0, 1);
         ch  = $urandom_range(0, 5);
         sel = $urandom_range(0, 9);
         nb  = $urandom_range(1, 5);
         if (ch < NUM_CH && sel < 7) seq = mtbl[ch];
         else if (ch < NUM_CH && sel == 7) seq = mtbl[ch] - 32'd1;
         else seq = $urandom();
         send_pkt(CH_W'(ch), seq, sel == 9, nb, 2, 1'b0);
      end
      tx_mode = 0;
      ack_mode = 0;

      budget = 0;
      while ((exp_tx_q.size() != 0 || exp_ack_q.size() != 0) && budget < 500) begin
         @(posedge clk);
         budget++;
      end
      @(negedge clk);
      chk(exp_tx_q.size() == 0, "tx_drain", $sformatf("got %0d beats missing, want 0",
                                                      exp_tx_q.size()));
      chk(exp_ack_q.size() == 0, "ack_drain", $sformatf("got %0d acks missing, want 0",
                                                        exp_ack_q.size()));
      chk(tx_if.tvalid === 1'b0 && ack_valid === 1'b0, "idle_end",
          $sformatf("got tx_tvalid=%b ack_valid=%b want 0 0", tx_if.tvalid, ack_valid));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
